alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the execute stage: it keeps the existing single-cycle ALUctrl operations and adds shifts, XOR, signed compare, an iterative multiply and an optional iterative divide/remainder. Operands arrive on a valid/ready input handshake, and the registered result leaves on a valid/ready output handshake. The pipeline control stalls the execute stage on `in_ready`/`out_valid` while a multi-cycle operation is running.

---
 rtl/alu_mc_if.sv | 25 ++
 rtl/alu_mc.sv | 209 ++++++++++++++++++++
 tb/tb_alu_mc.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result handshake bundle for the multi-cycle ALU.
interface alu_mc_if #(
  parameter int size = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [size-1:0] a;
  logic [size-1:0] b;
  logic [3:0]      ALUctrl;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, a, b, ALUctrl, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, a, b, ALUctrl, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: execute-stage ALU with single-cycle logic/arith/shift/compare ops
// and an iterative shift-add multiplier.
// Optional feature macro: ALU_MC_DIV_EN builds the iterative restoring
// divider for DIVU/REMU; without it those encodings return 0 in one cycle.
//
// state | meaning
// IDLE  | waiting for an operation
// BUSY  | iterating a multi-cycle op, one operand bit per cycle
// DONE  | result valid and held until out_ready
module alu_mc #(
  parameter int size = 32
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int SW = $clog2(size);
  localparam logic [SW-1:0] CNT_LAST = SW'(size - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  // acc: product accumulator / partial remainder
  // opa: shifted multiplicand / dividend shifting out, quotient shifting in
  // opb: multiplier shifting right / divisor
  logic [size-1:0] acc_q, acc_d;
  logic [size-1:0] opa_q, opa_d;
  logic [size-1:0] opb_q, opb_d;
  logic [size-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic            in_ready;
  logic            accept;
  logic            is_multi;
  logic [SW-1:0]   sh;
  logic [size-1:0] alu_res;
  logic [size-1:0] mul_acc_nx;

`ifdef ALU_MC_DIV_EN
  logic            div_q, div_d;
  logic            rem_q, rem_d;
  logic [size:0]   div_r;
  logic            div_ge;
  logic [size-1:0] div_rem_nx;
  logic [size-1:0] div_quo_nx;
`endif

  assign sh       = bus.b[SW-1:0];
  assign in_ready = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Single-cycle result, computed straight from the presented operands.
  always_comb begin
    alu_res = '0;
    case (bus.ALUctrl)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_SLTU: alu_res = {{(size-1){1'b0}}, bus.a < bus.b};
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLL:  alu_res = bus.a << sh;
      OP_SRL:  alu_res = bus.a >> sh;
      OP_SRA:  alu_res = $signed(bus.a) >>> sh;
      OP_SLT:  alu_res = {{(size-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      default: alu_res = '0;
    endcase
  end

  // Decide whether the presented encoding needs the iterative datapath.
  always_comb begin
    is_multi = (bus.ALUctrl == OP_MUL);
`ifdef ALU_MC_DIV_EN
    if (bus.ALUctrl == OP_DIVU || bus.ALUctrl == OP_REMU) is_multi = 1'b1;
`endif
  end

  // One shift-add multiply step.
  always_comb begin
    mul_acc_nx = opb_q[0] ? (acc_q + opa_q) : acc_q;
  end

`ifdef ALU_MC_DIV_EN
  // One restoring-division step; a zero divisor naturally yields
  // quotient all ones and remainder equal to the dividend.
  always_comb begin
    div_r      = {acc_q, opa_q[size-1]};
    div_ge     = (div_r >= {1'b0, opb_q});
    div_rem_nx = div_ge ? size'(div_r - {1'b0, opb_q}) : div_r[size-1:0];
    div_quo_nx = {opa_q[size-2:0], div_ge};
  end
`endif

  // Next-state and datapath control for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
`ifdef ALU_MC_DIV_EN
    div_d    = div_q;
    rem_d    = rem_q;
`endif
    if (state_q == BUSY) begin
      cnt_d = cnt_q + SW'(1);
`ifdef ALU_MC_DIV_EN
      if (div_q) begin
        acc_d = div_rem_nx;
        opa_d = div_quo_nx;
      end else begin
        acc_d = mul_acc_nx;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
`else
      acc_d = mul_acc_nx;
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
`endif
      if (cnt_q == CNT_LAST) begin
        state_d = DONE;
`ifdef ALU_MC_DIV_EN
        if (div_q) result_d = rem_q ? div_rem_nx : div_quo_nx;
        else       result_d = mul_acc_nx;
`else
        result_d = mul_acc_nx;
`endif
      end
    end else if (accept) begin
      if (is_multi) begin
        state_d = BUSY;
        cnt_d   = '0;
        acc_d   = '0;
        opa_d   = bus.a;
        opb_d   = bus.b;
`ifdef ALU_MC_DIV_EN
        div_d   = (bus.ALUctrl == OP_DIVU) || (bus.ALUctrl == OP_REMU);
        rem_d   = (bus.ALUctrl == OP_REMU);
`endif
      end else begin
        state_d  = DONE;
        result_d = alu_res;
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ALU_MC_DIV_EN
      div_q       <= 1'b0;
      rem_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ALU_MC_DIV_EN
      div_q       <= div_d;
      rem_q       <= rem_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed checks of alu_mc against a plain
// arithmetic reference model.
module tb_alu_mc;
  localparam int W = 32;
  localparam int MC_LAT = W + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.size(W)) bus();
  alu_mc #(.size(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  function automatic logic is_multi_op(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
    return (op == 4'b1010) || (op == 4'b1101) || (op == 4'b1110);
`else
    return (op == 4'b1010);
`endif
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1000: return a ^ b;
      4'b0011: return a << sh;
      4'b0100: return a >> sh;
      4'b0101: return a[31] ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
      4'b1001: return (a[31] != b[31]) ? {31'd0, a[31]} : ((a < b) ? 32'd1 : 32'd0);
      4'b1010: return a * b;
`ifdef ALU_MC_DIV_EN
      4'b1101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1110: return (b == 0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] rand_single_op();
    logic [3:0] op;
    do op = 4'($urandom_range(0, 15)); while (is_multi_op(op));
    return op;
  endfunction

  // Issue one op from IDLE with out_ready high; report result and timing.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic z, output int lat,
                       output int busy_n, output int rdy_busy_n);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.ALUctrl   = op;
    bus.a         = a;
    bus.b         = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.ALUctrl  = 4'($urandom);
    lat = 1; busy_n = 0; rdy_busy_n = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.busy) busy_n++;
      if (bus.busy && bus.in_ready) rdy_busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    z   = bus.zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.ALUctrl = 4'b0010; bus.a = 32'd1; bus.b = 32'd1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.result !== 32'd0) begin miscompares++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    vectors++; if (bus.zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero got=%b exp=1", bus.zero); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_accept out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_single();
    logic [31:0] res, exp;
    logic z;
    int lat, bn, rb;
    logic [3:0] op;
    logic [31:0] a, b;
    do_op(4'b1001, 32'hFFFF_FFFF, 32'd1, res, z, lat, bn, rb);
    vectors++; if (res !== 32'd1) begin miscompares++; $display("FAIL slt_neg got=%h exp=00000001", res); end
    do_op(4'b0111, 32'hFFFF_FFFF, 32'd1, res, z, lat, bn, rb);
    vectors++; if (res !== 32'd0) begin miscompares++; $display("FAIL sltu_big got=%h exp=00000000", res); end
    do_op(4'b0101, 32'h8000_0000, 32'd4, res, z, lat, bn, rb);
    vectors++; if (res !== 32'hF800_0000) begin miscompares++; $display("FAIL sra_fill got=%h exp=f8000000", res); end
    for (int i = 0; i < 40; i++) begin
      op = rand_single_op();
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      exp = ref_alu(op, a, b);
      do_op(op, a, b, res, z, lat, bn, rb);
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL single_res op=%b a=%h b=%h got=%h exp=%h", op, a, b, res, exp); end
      vectors++; if (z !== (exp == 32'd0)) begin miscompares++; $display("FAIL single_zero op=%b got=%b exp=%b", op, z, exp == 32'd0); end
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL single_lat op=%b got=%0d exp=1", op, lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic [31:0] a, b, exp;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 0)      begin op = 4'b0010; a = 32'h7FFF_FFFF; b = 32'd1; end
      else if (i == 1) begin op = 4'b0110; a = 32'd5; b = 32'd5; end
      else             begin op = rand_single_op(); a = $urandom; b = $urandom; end
      exp = ref_alu(op, a, b);
      bus.in_valid = 1'b1; bus.ALUctrl = op; bus.a = a; bus.b = b;
      @(posedge clk); #1;
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, bus.out_valid); end
      vectors++; if (bus.result !== exp) begin miscompares++; $display("FAIL b2b_res i=%0d op=%b got=%h exp=%h", i, op, bus.result, exp); end
      vectors++; if (bus.zero !== (exp == 32'd0)) begin miscompares++; $display("FAIL b2b_zero i=%0d got=%b exp=%b", i, bus.zero, exp == 32'd0); end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_mul();
    logic [31:0] res, exp, a, b;
    logic z;
    int lat, bn, rb;
    do_op(4'b1010, 32'hFFFF_FFFF, 32'd3, res, z, lat, bn, rb);
    vectors++; if (res !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL mul_dir_res got=%h exp=fffffffd", res); end
    vectors++; if (lat !== MC_LAT) begin miscompares++; $display("FAIL mul_dir_lat got=%0d exp=%0d", lat, MC_LAT); end
    vectors++; if (bn !== W) begin miscompares++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", bn, W); end
    vectors++; if (rb !== 0) begin miscompares++; $display("FAIL mul_ready_while_busy got=%0d exp=0", rb); end
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = (i == 0) ? 32'd0 : $urandom;
      exp = ref_alu(4'b1010, a, b);
      do_op(4'b1010, a, b, res, z, lat, bn, rb);
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL mul_res a=%h b=%h got=%h exp=%h", a, b, res, exp); end
      vectors++; if (lat !== MC_LAT) begin miscompares++; $display("FAIL mul_lat got=%0d exp=%0d", lat, MC_LAT); end
    end
  endtask

  task automatic test_div();
    logic [31:0] res, exp, a, b;
    logic z;
    int lat, bn, rb;
    logic [3:0] op;
`ifdef ALU_MC_DIV_EN
    do_op(4'b1101, 32'd100, 32'd7, res, z, lat, bn, rb);
    vectors++; if (res !== 32'd14) begin miscompares++; $display("FAIL divu_dir got=%h exp=0000000e", res); end
    vectors++; if (lat !== MC_LAT) begin miscompares++; $display("FAIL divu_lat got=%0d exp=%0d", lat, MC_LAT); end
    do_op(4'b1110, 32'd100, 32'd7, res, z, lat, bn, rb);
    vectors++; if (res !== 32'd2) begin miscompares++; $display("FAIL remu_dir got=%h exp=00000002", res); end
    vectors++; if (lat !== MC_LAT) begin miscompares++; $display("FAIL remu_lat got=%0d exp=%0d", lat, MC_LAT); end
    do_op(4'b1101, 32'd9, 32'd0, res, z, lat, bn, rb);
    vectors++; if (res !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL divu_by0 got=%h exp=ffffffff", res); end
    vectors++; if (lat !== MC_LAT) begin miscompares++; $display("FAIL divu_by0_lat got=%0d exp=%0d", lat, MC_LAT); end
    do_op(4'b1110, 32'd9, 32'd0, res, z, lat, bn, rb);
    vectors++; if (res !== 32'd9) begin miscompares++; $display("FAIL remu_by0 got=%h exp=00000009", res); end
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 0) ? 4'b1101 : 4'b1110;
      a = $urandom;
      b = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      exp = ref_alu(op, a, b);
      do_op(op, a, b, res, z, lat, bn, rb);
      vectors++; if (res !== exp) begin miscompares++; $display("FAIL div_res op=%b a=%h b=%h got=%h exp=%h", op, a, b, res, exp); end
      vectors++; if (lat !== MC_LAT) begin miscompares++; $display("FAIL div_rand_lat got=%0d exp=%0d", lat, MC_LAT); end
    end
`else
    for (int i = 0; i < 2; i++) begin
      op = (i == 0) ? 4'b1101 : 4'b1110;
      do_op(op, 32'd100, 32'd7, res, z, lat, bn, rb);
      vectors++; if (res !== 32'd0) begin miscompares++; $display("FAIL nodiv_res op=%b got=%h exp=0", op, res); end
      vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL nodiv_zero op=%b got=%b exp=1", op, z); end
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL nodiv_lat op=%b got=%0d exp=1", op, lat); end
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, exp, a2, b2, exp2;
    int n;
    a = $urandom; b = $urandom;
    exp = ref_alu(4'b1010, a, b);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.ALUctrl = 4'b1010; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_done got=%b exp=1", bus.out_valid); end
    bus.in_valid = 1'b1; bus.ALUctrl = 4'b0001; bus.a = $urandom; bus.b = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.result !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cyc=%0d res=%h exp=%h valid=%b in_ready=%b (exp valid=1 in_ready=0)", i, bus.result, exp, bus.out_valid, bus.in_ready);
      end
    end
    a2 = $urandom; b2 = $urandom;
    exp2 = ref_alu(4'b0010, a2, b2);
    bus.ALUctrl = 4'b0010; bus.a = a2; bus.b = b2;
    bus.out_ready = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_new_valid got=%b exp=1", bus.out_valid); end
    vectors++; if (bus.result !== exp2) begin miscompares++; $display("FAIL bp_new_res got=%h exp=%h", bus.result, exp2); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.ALUctrl = 4'b1010; bus.a = $urandom; bus.b = $urandom;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rmid_busy10 got=%b exp=1", bus.busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_idle in_ready=%b busy=%b exp in_ready=1 busy=0", bus.in_ready, bus.busy); end
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got=%b exp=0", bus.out_valid); end
    vectors++; if (bus.result !== 32'd0 || bus.zero !== 1'b1) begin miscompares++; $display("FAIL rmid_result got=%h zero=%b exp=0 zero=1", bus.result, bus.zero); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rmid_stale got=%0d valid cycles exp=0", seen); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.ALUctrl = '0;
    test_reset();
    test_back_to_back();
    test_single();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
